// File: rtl/midi_msg_tx.sv
// MIDI OUT transmitter: whole messages plus a real-time byte stream, serialised
// as 8N1 frames on txd with optional running-status compression.
module midi_msg_tx #(
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] prescale,
  input  logic [7:0]  msg_status,
  input  logic [7:0]  msg_data1,
  input  logic [7:0]  msg_data2,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  rt_byte,
  input  logic        rt_valid,
  output logic        rt_ready,
  output logic        txd,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a byte/message transfers on a rising clk edge where valid && ready;
  // ready is low from the next cycle until the cycle after its last stop bit ends.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [18:0] r_cnt, w_cnt_nxt;
  logic [18:0] r_period, w_period_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_txd, w_txd_nxt;
  logic        r_cur_rt, w_cur_rt_nxt;

  logic [7:0]  r_msg_b0, r_msg_b1, r_msg_b2;
  logic [1:0]  r_msg_left;
  logic        r_msg_pend;
  logic [7:0]  r_rt_byte;
  logic        r_rt_pend;
  logic [7:0]  r_last;

  logic [18:0] w_period;
  logic [1:0]  w_len;
  logic        w_voice, w_skip;
  logic        w_msg_acc, w_rt_acc;
  logic        w_stop_end, w_can_launch, w_launch, w_launch_rt;
  logic        w_rt_avail, w_rt_done, w_msg_done;

  assign w_period  = (prescale == 16'd0) ? 19'd8 : {prescale, 3'b000};
  assign w_msg_acc = msg_valid && !r_msg_pend;
  assign w_rt_acc  = rt_valid && !r_rt_pend;

  // Message length and running-status decision, taken at acceptance time.
  always_comb begin
    w_len   = 2'd0;
    w_voice = msg_status[7] && (msg_status[7:4] != 4'hF);
    if (msg_status[7]) begin
      if (msg_status < 8'hC0)      w_len = 2'd3;
      else if (msg_status < 8'hE0) w_len = 2'd2;
      else if (msg_status < 8'hF0) w_len = 2'd3;
      else if (msg_status == 8'hF1 || msg_status == 8'hF3) w_len = 2'd2;
      else if (msg_status == 8'hF2) w_len = 2'd3;
      else                          w_len = 2'd1;
    end
    w_skip = RUNNING_STATUS && w_voice && (msg_status == r_last);
  end

  // A byte boundary is either an idle serialiser or the last clock of a stop bit.
  assign w_stop_end   = (r_state == S_STOP) && (r_cnt == 19'd0);
  assign w_can_launch = (r_state == S_IDLE) || w_stop_end;
  assign w_rt_avail   = r_rt_pend && !((r_state != S_IDLE) && r_cur_rt);
  assign w_launch     = w_can_launch && (w_rt_avail || (r_msg_left != 2'd0));
  assign w_launch_rt  = w_can_launch && w_rt_avail;
  assign w_rt_done    = w_stop_end && r_cur_rt;
  assign w_msg_done   = r_msg_pend && (r_msg_left == 2'd0) &&
                        !((r_state != S_IDLE) && !r_cur_rt && !w_stop_end);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_txd_nxt    = r_txd;
    w_cur_rt_nxt = r_cur_rt;
    if (w_launch) begin
      w_state_nxt  = S_START;
      w_period_nxt = w_period;
      w_cnt_nxt    = w_period - 19'd1;
      w_shift_nxt  = w_launch_rt ? r_rt_byte : r_msg_b0;
      w_txd_nxt    = 1'b0;
      w_cur_rt_nxt = w_launch_rt;
    end else if (r_state != S_IDLE && r_cnt != 19'd0) begin
      w_cnt_nxt = r_cnt - 19'd1;
    end else begin
      case (r_state)
        S_START: begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = r_period - 19'd1;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end
        S_DATA: begin
          w_cnt_nxt = r_period - 19'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
        S_STOP:  w_state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_period <= 19'd8;
      r_bit    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_cur_rt <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
      r_cur_rt <= w_cur_rt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg_b0   <= '0;
      r_msg_b1   <= '0;
      r_msg_b2   <= '0;
      r_msg_left <= '0;
      r_msg_pend <= 1'b0;
      r_rt_byte  <= '0;
      r_rt_pend  <= 1'b0;
      r_last     <= 8'h00;
    end else begin
      if (w_msg_acc) begin
        r_msg_pend <= 1'b1;
        if (w_skip) begin
          r_msg_b0   <= {1'b0, msg_data1[6:0]};
          r_msg_b1   <= {1'b0, msg_data2[6:0]};
          r_msg_left <= w_len - 2'd1;
        end else begin
          r_msg_b0   <= msg_status;
          r_msg_b1   <= {1'b0, msg_data1[6:0]};
          r_msg_b2   <= {1'b0, msg_data2[6:0]};
          r_msg_left <= w_len;
        end
        // System common/exclusive cancels running status; real-time leaves it alone.
        if (w_voice) r_last <= msg_status;
        else if (msg_status[7:3] == 5'b11110) r_last <= 8'h00;
      end else begin
        if (w_launch && !w_launch_rt) begin
          r_msg_b0   <= r_msg_b1;
          r_msg_b1   <= r_msg_b2;
          r_msg_left <= r_msg_left - 2'd1;
        end
        if (w_msg_done) r_msg_pend <= 1'b0;
      end
      if (w_rt_acc) begin
        r_rt_byte <= rt_byte;
        r_rt_pend <= 1'b1;
      end else if (w_rt_done) begin
        r_rt_pend <= 1'b0;
      end
    end
  end

  assign txd       = r_txd;
  assign msg_ready = !r_msg_pend;
  assign rt_ready  = !r_rt_pend;
  assign busy      = (r_state != S_IDLE) || r_msg_pend || r_rt_pend;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Bench for midi_msg_tx: a UART line monitor decodes txd into bytes, which are
// compared with byte lists derived from MIDI message rules.
module tb_midi_msg_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] prescale;
  logic [7:0]  msg_status, msg_data1, msg_data2, rt_byte;
  logic        msg_valid, rt_valid;
  logic        msg_ready, rt_ready, txd, busy;
  logic [1:0]  dbg_state;

  midi_msg_tx #(.RUNNING_STATUS(1'b1)) dut (
    .clk(clk), .reset(reset), .prescale(prescale),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .rt_byte(rt_byte), .rt_valid(rt_valid), .rt_ready(rt_ready),
    .txd(txd), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset infrastructure
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int cur_p = 8;
  int frame_err = 0;
  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_rt_q[$];
  logic [7:0] m_last;

  // Line monitor: decodes 8N1 frames at mid-bit, abandons a frame on reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && txd === 1'b0) begin
        int t0;
        bit ok;
        logic [7:0] b;
        logic s0, s1;
        t0 = cyc; ok = 1'b1; b = '0;
        for (int i = 0; i < cur_p / 2 && ok; i++) begin @(negedge clk); if (reset) ok = 1'b0; end
        s0 = txd;
        for (int k = 0; k < 8 && ok; k++) begin
          for (int i = 0; i < cur_p && ok; i++) begin @(negedge clk); if (reset) ok = 1'b0; end
          b[k] = txd;
        end
        for (int i = 0; i < cur_p && ok; i++) begin @(negedge clk); if (reset) ok = 1'b0; end
        s1 = txd;
        if (ok) begin
          got_q.push_back(b);
          got_t.push_back(t0);
          if (s0 !== 1'b0 || s1 !== 1'b1) frame_err++;
        end
      end
    end
  end

  // Reference model: expected wire bytes of one message under running status.
  function automatic void model_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int n;
    bit voice;
    if (s < 8'h80) return;
    if (s < 8'hC0) n = 3;
    else if (s < 8'hE0) n = 2;
    else if (s < 8'hF0) n = 3;
    else if (s == 8'hF1 || s == 8'hF3) n = 2;
    else if (s == 8'hF2) n = 3;
    else n = 1;
    voice = (s < 8'hF0);
    if (!(voice && s == m_last)) exp_q.push_back(s);
    if (n >= 2) exp_q.push_back(d1 & 8'h7F);
    if (n == 3) exp_q.push_back(d2 & 8'h7F);
    if (voice) m_last = s;
    else if (s < 8'hF8) m_last = 8'h00;
  endfunction

  // Driver tasks
  task automatic set_prescale(input logic [15:0] p);
    prescale = p;
    cur_p = (p == 16'd0) ? 8 : int'(p) * 8;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; msg_valid = 1'b0; rt_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_q.delete(); got_t.delete(); exp_q.delete(); exp_rt_q.delete();
    m_last = 8'h00; frame_err = 0;
  endtask

  task automatic send_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2, output int acc);
    int n = 0;
    @(negedge clk);
    while (msg_ready !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) begin total++; bad++; $display("FAIL msg_ready_timeout got=%b want=1", msg_ready); end
    msg_status = s; msg_data1 = d1; msg_data2 = d2; msg_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    msg_valid = 1'b0;
  endtask

  task automatic send_rt(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (rt_ready !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) begin total++; bad++; $display("FAIL rt_ready_timeout got=%b want=1", rt_ready); end
    rt_byte = b; rt_valid = 1'b1;
    @(posedge clk); #1;
    rt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout busy=%b want=0", busy); end
    repeat (2) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset;
    reset = 1'b1; msg_valid = 1'b0; rt_valid = 1'b0;
    msg_status = '0; msg_data1 = '0; msg_data2 = '0; rt_byte = '0;
    set_prescale(16'd1);
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1)       begin bad++; $display("FAIL rst_txd got=%b want=1", txd); end
    total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL rst_msg_ready got=%b want=1", msg_ready); end
    total++; if (rt_ready !== 1'b1)  begin bad++; $display("FAIL rst_rt_ready got=%b want=1", rt_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_rst_idle txd=%b busy=%b want 1/0", txd, busy); end
  endtask

  task automatic test_basic;
    int acc, low;
    logic [7:0] e[$] = '{8'h90, 8'h3C, 8'h64};
    do_reset();
    set_prescale(16'd134);
    send_msg(8'h90, 8'h3C, 8'h64, acc);
    low = 0;
    @(negedge clk);
    while (msg_ready === 1'b0 && low < 40000) begin low++; @(negedge clk); end
    total++; if (low != 32161) begin bad++; $display("FAIL basic_ready_low got=%0d want=32161", low); end
    wait_idle(2000);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== e[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_q[i], e[i]); end
    end
    if (got_t.size() == 3) begin
      total++; if (got_t[0] != acc + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", got_t[0], acc + 1); end
      total++; if (got_t[1] - got_t[0] != 10720) begin bad++; $display("FAIL basic_gap1 got=%0d want=10720", got_t[1] - got_t[0]); end
      total++; if (got_t[2] - got_t[1] != 10720) begin bad++; $display("FAIL basic_gap2 got=%0d want=10720", got_t[2] - got_t[1]); end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL basic_framing got=%0d want=0", frame_err); end
  endtask

  task automatic test_running_status;
    int acc;
    logic [7:0] e[$] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00, 8'h80, 8'h3C, 8'h00,
                         8'hF6, 8'h80, 8'h3C, 8'h00};
    do_reset();
    set_prescale(16'd1);
    send_msg(8'h90, 8'h3C, 8'h64, acc);
    send_msg(8'h90, 8'h3E, 8'h00, acc);
    send_msg(8'h80, 8'h3C, 8'h00, acc);
    send_msg(8'hF6, 8'h11, 8'h22, acc);
    send_msg(8'h80, 8'h3C, 8'h00, acc);
    wait_idle(2000);
    total++; if (got_q.size() != e.size()) begin bad++; $display("FAIL rs_count got=%0d want=%0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== e[i]) begin bad++; $display("FAIL rs_byte%0d got=%h want=%h", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_rt_interleave;
    int acc;
    logic [7:0] e[$] = '{8'h90, 8'hF8, 8'h3C, 8'h64, 8'h40, 8'h10};
    do_reset();
    set_prescale(16'd2);
    send_msg(8'h90, 8'h3C, 8'h64, acc);
    repeat (20) @(negedge clk);
    send_rt(8'hF8);
    @(negedge clk);
    total++; if (rt_ready !== 1'b0) begin bad++; $display("FAIL rt_ready_drop got=%b want=0", rt_ready); end
    wait_idle(3000);
    send_msg(8'h90, 8'h40, 8'h10, acc);
    wait_idle(3000);
    total++; if (got_q.size() != e.size()) begin bad++; $display("FAIL rt_count got=%0d want=%0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== e[i]) begin bad++; $display("FAIL rt_byte%0d got=%h want=%h", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] e[$] = '{8'hFA, 8'h91, 8'h01, 8'h02};
    do_reset();
    set_prescale(16'd1);
    @(negedge clk);
    msg_status = 8'h91; msg_data1 = 8'h01; msg_data2 = 8'h02; msg_valid = 1'b1;
    rt_byte = 8'hFA; rt_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0; rt_valid = 1'b0;
    wait_idle(2000);
    total++; if (got_q.size() != e.size()) begin bad++; $display("FAIL simul_count got=%0d want=%0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== e[i]) begin bad++; $display("FAIL simul_byte%0d got=%h want=%h", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_prescale_zero;
    int acc;
    do_reset();
    set_prescale(16'd0);
    send_msg(8'hC5, 8'hFF, 8'h33, acc);
    wait_idle(2000);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL pc_count got=%0d want=2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== 8'hC5) begin bad++; $display("FAIL pc_status got=%h want=c5", got_q[0]); end
      total++; if (got_q[1] !== 8'h7F) begin bad++; $display("FAIL pc_data got=%h want=7f", got_q[1]); end
      total++; if (got_t[1] - got_t[0] != 80) begin bad++; $display("FAIL pc_frame_len got=%0d want=80", got_t[1] - got_t[0]); end
      total++; if (got_t[0] != acc + 1) begin bad++; $display("FAIL pc_latency got=%0d want=%0d", got_t[0], acc + 1); end
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    logic [7:0] e[$] = '{8'h90, 8'h3C, 8'h64};
    do_reset();
    set_prescale(16'd2);
    send_msg(8'h90, 8'h3C, 8'h64, acc);
    repeat (40) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (txd !== 1'b1)       begin bad++; $display("FAIL mid_rst_txd got=%b want=1", txd); end
    total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", msg_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    got_q.delete(); got_t.delete();
    send_msg(8'h90, 8'h3C, 8'h64, acc);
    wait_idle(3000);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL mid_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== e[i]) begin bad++; $display("FAIL mid_byte%0d got=%h want=%h", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_discard;
    int acc, lows;
    do_reset();
    set_prescale(16'd1);
    send_msg(8'h45, 8'h12, 8'h34, acc);
    @(negedge clk);
    total++; if (msg_ready !== 1'b0) begin bad++; $display("FAIL disc_ready_drop got=%b want=0", msg_ready); end
    @(negedge clk);
    total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL disc_ready_back got=%b want=1", msg_ready); end
    lows = 0;
    repeat (40) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL disc_txd_low got=%0d want=0", lows); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL disc_frames got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_random;
    logic [7:0] gm[$];
    logic [7:0] gr[$];
    do_reset();
    set_prescale(16'd1);
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          int acc, r;
          logic [7:0] s, d1, d2;
          r = $urandom_range(0, 9);
          if (r == 0) s = 8'($urandom_range(0, 8'h7F));
          else if (r <= 6) s = 8'({$urandom_range(8, 14), 4'h0}) | 8'($urandom_range(0, 1));
          else s = 8'($urandom_range(8'hF0, 8'hF7));
          d1 = 8'($urandom); d2 = 8'($urandom);
          model_msg(s, d1, d2);
          send_msg(s, d1, d2, acc);
          repeat ($urandom_range(0, 30)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          logic [7:0] b;
          repeat ($urandom_range(20, 150)) @(negedge clk);
          b = 8'hF8 + 8'($urandom_range(0, 7));
          exp_rt_q.push_back(b);
          send_rt(b);
        end
      end
    join
    wait_idle(20000);
    foreach (got_q[i]) if (got_q[i] >= 8'hF8) gr.push_back(got_q[i]); else gm.push_back(got_q[i]);
    total++; if (gm.size() != exp_q.size()) begin bad++; $display("FAIL rnd_msg_count got=%0d want=%0d", gm.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gm.size(); i++) begin
      total++; if (gm[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_msg_byte%0d got=%h want=%h", i, gm[i], exp_q[i]); end
    end
    total++; if (gr.size() != exp_rt_q.size()) begin bad++; $display("FAIL rnd_rt_count got=%0d want=%0d", gr.size(), exp_rt_q.size()); end
    for (int i = 0; i < exp_rt_q.size() && i < gr.size(); i++) begin
      total++; if (gr[i] !== exp_rt_q[i]) begin bad++; $display("FAIL rnd_rt_byte%0d got=%h want=%h", i, gr[i], exp_rt_q[i]); end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL rnd_framing got=%0d want=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_running_status();
    test_rt_interleave();
    test_simultaneous();
    test_prescale_zero();
    test_reset_mid();
    test_discard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
